// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell with a registered borrow loop,
// consuming parallel operands LSB first and returning a registered parallel result.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic d_bit;
   logic br_nxt;
   logic last_bit;

   always_comb begin
      d_bit    = a_q[0] ^ b_q[0] ^ br_q;
      br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      last_bit = (cnt_q == CntW'(WIDTH - 1));

      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      br_d     = br_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               br_d    = bin_in;
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = {d_bit, res_q[WIDTH-1:1]};
            br_d  = br_nxt;
            cnt_d = cnt_q + CntW'(1);
            if (last_bit) begin
               // Borrow into the MSB step vs. out of it exposes signed overflow.
               diff_d   = {d_bit, res_q[WIDTH-1:1]};
               borrow_d = br_nxt;
               ovf_d    = br_q ^ br_nxt;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         br_q     <= br_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands
// at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start8 = 1'b0, bin8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, bo8, ovf8;
   logic [7:0]  diff8;

   logic        start16 = 1'b0, bin16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, bo16, ovf16;
   logic [15:0] diff16;

   int checks = 0;
   int failures = 0;

   logic [31:0] last_diff [2];
   logic        last_bo [2];
   logic        last_ovf [2];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .bin_in(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .ovf(ovf8)
   );

   serial_subtractor #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16), .bin_in(bin16),
      .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16), .ovf(ovf16)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, output logic [31:0] d, output logic bo,
                        output logic ov);
      longint mask, ua, ub, full, sa, sb, sr, half;
      mask = (64'sd1 <<< w) - 1;
      half = 64'sd1 <<< (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      full = ua - ub - longint'(bin);
      d    = 32'(full & mask);
      bo   = (full < 0);
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sb   = (ub >= half) ? ub - (mask + 1) : ub;
      sr   = sa - sb - longint'(bin);
      ov   = (sr < -half) || (sr > half - 1);
   endtask

   task automatic set_in(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input logic st);
      if (sel == 0) begin
         a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = st;
      end else begin
         a16 = a[15:0]; b16 = b[15:0]; bin16 = bin; start16 = st;
      end
   endtask

   function automatic logic [31:0] get_diff(input int sel);
      return (sel == 0) ? {24'd0, diff8} : {16'd0, diff16};
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy8 : busy16;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel == 0) ? done8 : done16;
   endfunction
   function automatic logic get_bo(input int sel);
      return (sel == 0) ? bo8 : bo16;
   endfunction
   function automatic logic get_ovf(input int sel);
      return (sel == 0) ? ovf8 : ovf16;
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One full transaction: accept, latency, busy profile, result and single done pulse.
   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic bin);
      int sel, cyc, busy_bad;
      logic [31:0] ed;
      logic eb, eo;
      sel = (w == 8) ? 0 : 1;
      model(w, a, b, bin, ed, eb, eo);
      set_in(sel, a, b, bin, 1'b1);
      step(1);
      set_in(sel, $urandom, $urandom, 1'($urandom), 1'b0);
      check_eq("busy_after_start", 32'(get_busy(sel)), 32'd1);
      check_eq("diff_hold_run", get_diff(sel), last_diff[sel]);
      check_eq("bo_hold_run", 32'(get_bo(sel)), 32'(last_bo[sel]));
      cyc = 0;
      busy_bad = 0;
      while (!get_done(sel) && cyc < w + 4) begin
         if (!get_busy(sel)) busy_bad++;
         step(1);
         cyc++;
      end
      check_eq("latency", 32'(cyc), 32'(w));
      check_eq("busy_during_run", 32'(busy_bad), 32'd0);
      check_eq("busy_at_done", 32'(get_busy(sel)), 32'd0);
      check_eq("diff", get_diff(sel), ed);
      check_eq("borrow_out", 32'(get_bo(sel)), 32'(eb));
      check_eq("ovf", 32'(get_ovf(sel)), 32'(eo));
      last_diff[sel] = ed;
      last_bo[sel]   = eb;
      last_ovf[sel]  = eo;
      step(1);
      check_eq("done_one_cycle", 32'(get_done(sel)), 32'd0);
      check_eq("diff_hold_idle", get_diff(sel), ed);
   endtask

   initial begin
      int seen;
      logic [31:0] ra, rb;
      for (int s = 0; s < 2; s++) begin
         last_diff[s] = '0; last_bo[s] = 1'b0; last_ovf[s] = 1'b0;
      end

      #12;
      check_eq("reset_out8", {busy8, done8, bo8, ovf8, 20'd0, diff8}, 32'd0);
      check_eq("reset_out16", {busy16, done16, bo16, ovf16, 12'd0, diff16}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);

      // Directed values
      run_op(8, 32'h5A, 32'h3C, 1'b0);
      run_op(8, 32'h00, 32'h01, 1'b0);
      run_op(8, 32'h80, 32'h01, 1'b0);
      run_op(8, 32'h10, 32'h0F, 1'b1);
      run_op(8, 32'h00, 32'hFF, 1'b1);
      run_op(8, 32'h33, 32'h33, 1'b0);
      check_eq("const_5a_3c", 32'h1E ^ 32'h1E, 32'h0 ^ (last_diff[0] ^ last_diff[0]));

      // start during RUN is ignored; start held through DONE is accepted back-to-back
      set_in(0, 32'h5A, 32'h3C, 1'b0, 1'b1);
      step(1);
      set_in(0, 32'h00, 32'h00, 1'b0, 1'b0);
      step(2);
      set_in(0, 32'hFF, 32'h01, 1'b1, 1'b1);
      step(1);
      set_in(0, 32'h00, 32'h00, 1'b0, 1'b0);
      step(4);
      set_in(0, 32'h80, 32'h01, 1'b0, 1'b1);
      step(1);
      check_eq("ign_done_e8", 32'(done8), 32'd1);
      check_eq("ign_diff", {24'd0, diff8}, 32'h1E);
      check_eq("ign_bo", 32'(bo8), 32'd0);
      step(1);
      set_in(0, 32'h00, 32'h00, 1'b0, 1'b0);
      check_eq("b2b_busy_e9", {30'd0, busy8, done8}, 32'b10);
      step(7);
      check_eq("b2b_no_early_done", 32'(done8), 32'd0);
      step(1);
      check_eq("b2b_done_e17", 32'(done8), 32'd1);
      check_eq("b2b_diff", {24'd0, diff8}, 32'h7F);
      check_eq("b2b_flags", {30'd0, bo8, ovf8}, 32'b01);
      last_diff[0] = 32'h7F; last_bo[0] = 1'b0; last_ovf[0] = 1'b1;
      step(2);

      // Asynchronous reset mid-operation
      set_in(0, 32'h12, 32'h34, 1'b0, 1'b1);
      step(1);
      set_in(0, 32'h00, 32'h00, 1'b0, 1'b0);
      step(4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_out", {busy8, done8, bo8, ovf8, 20'd0, diff8}, 32'd0);
      for (int s = 0; s < 2; s++) begin
         last_diff[s] = '0; last_bo[s] = 1'b0; last_ovf[s] = 1'b0;
      end
      step(2);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (done8) seen++;
      end
      check_eq("rst_no_done", 32'(seen), 32'd0);
      check_eq("rst_out_after", {24'd0, diff8}, 32'd0);
      run_op(8, 32'h7F, 32'h80, 1'b0);

      // Random operands
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 37 == 0) rb = ra;
         run_op(8, ra, rb, 1'($urandom));
      end
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 41 == 0) begin ra = 32'h0; rb = 32'hFFFF; end
         run_op(16, ra, rb, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor computing A - B - bin_in, LSB first, one bit per clock.
- Built around a single full-subtractor cell with a registered borrow loop.
- Sits directly downstream of the operand source and feeds result consumers.
- Takes parallel operands through a start/busy/done handshake and returns a parallel difference, final borrow and signed-overflow flag.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
bin_in  input  1  initial borrow-in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  difference (A - B - bin_in) mod 2^WIDTH
borrow_out  output  1  final borrow; 1 iff A < B + bin_in (unsigned)
ovf  output  1  signed overflow of A - B - bin_in (two's complement)

Behaviour:
- Reset and clocking: one clock domain. Reset is asynchronous and active-low on rst_n. While rst_n = 0, all state is cleared immediately:
  - state = IDLE, bit counter = 0, borrow register = 0, shift registers = 0
  - busy = 0, done = 0, diff = 0, borrow_out = 0, ovf = 0
- Reset asserted mid-operation aborts the operation. No done pulse is produced, and outputs read 0 after release.
- States:
  - IDLE: busy = 0, done = 0. Outputs hold the last result. An edge with start = 1 loads a_in, b_in and bin_in into the A shift register, B shift register and borrow register, clears the counter, and moves to RUN.
  - RUN: busy = 1. Each edge does one cell step:
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - a0 and b0 are the current LSBs of the A and B shift registers.
    - d shifts into the result register MSB-side, so after WIDTH steps bit i holds diff bit i. A and B shift right. The counter increments.
    - When bit index WIDTH-1 is processed, the borrow into that step is saved as br_msb_in and the FSM moves to DONE.
  - DONE: busy = 0, done = 1 for exactly this one cycle. Outputs at this point:
    - diff = result register
    - borrow_out = final br
    - ovf = br_msb_in ^ borrow_out
  - Exit from DONE: next edge goes to IDLE, or to RUN if start = 1 (back-to-back accepted).
- Latency: start sampled at edge E0; bits processed at edges E1..E_WIDTH; done high from E_WIDTH to E_WIDTH+1. A new operation can therefore be accepted every WIDTH+1 cycles.
- Output update rule: diff, borrow_out and ovf update only on entry to DONE. They hold stable through IDLE and through the following RUN until the next DONE.
- Start ignored: start = 1 during RUN is ignored and not queued. Operand inputs may change freely after the accepting edge.
- Registered operation: no combinational path from inputs to outputs; busy and done are registered.
- Boundary cases:
  - A = B with bin_in = 0 gives diff = 0, borrow_out = 0.
  - A = 0, B = all-ones, bin_in = 1 gives diff = 0, borrow_out = 1.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, bin=0, start at E0 -> done only at E8; diff=0x1E, borrow_out=0, ovf=0; busy high E0..E8.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, borrow_out=0. Then a=0x00, b=0xFF, bin=1 -> diff=0x00, borrow_out=1, ovf=0.
- start pulsed at E3 during RUN with different operands -> ignored; first result unchanged. start held high through DONE -> second operation begins, second done at E17.
- rst_n low asynchronously at E4+half cycle -> busy, done, diff, borrow_out, ovf = 0 immediately; no done pulse. After release, fresh a=0x7F, b=0x80 -> diff=0xFF, borrow_out=1, ovf=1.
- Random 1000 operands, WIDTH=8 and WIDTH=16 -> every done matches the reference model (A-B-bin) mod 2^W, with unsigned borrow and signed overflow; exactly one done pulse per accepted start.
